// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, owner IDs,
// default response timeout and the round-robin owner pick.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  localparam int TIMEOUT_DEFAULT = 16;

  // A lone requester always wins; on a conflict the one that did not go last wins.
  function automatic logic rr_pick(input logic ra, input logic rb, input logic last);
    return (ra && rb) ? ~last : rb;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// Two-input word mux used to steer the owner's address onto the memory port.
module mux #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch (A) and LSU (B) onto one memory port and sequences a single
// outstanding request/response transaction, aborting when the response never comes.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic [AW-1:0] addr_a,
  input  logic          req_b,
  input  logic [AW-1:0] addr_b,
  input  logic          we_b,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  input  logic          mem_rvalid,
  output logic          sel,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          done_a,
  output logic          done_b,
  output logic          err_o
);

  localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic          last_owner;
  logic [CW-1:0] cnt;
  logic          owner_next;
  logic          in_req;
  logic          in_wait;
  logic          timeout_hit;

  assign owner_next  = rr_pick(req_a, req_b, last_owner);
  assign in_req      = (state == ST_REQ);
  assign in_wait     = (state == ST_WAIT);
  assign timeout_hit = in_wait && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel        <= OWN_A;
      last_owner <= OWN_B;
      cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_a || req_b) begin
            sel        <= owner_next;
            last_owner <= owner_next;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            cnt   <= '0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Counter saturates at the abort threshold rather than wrapping.
          if (cnt != CNT_LAST) cnt <= cnt + CW'(1);
          if (mem_rvalid || (cnt == CNT_LAST)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mux #(.WIDTH(AW)) u_addr_mux (
    .a (addr_a),
    .b (addr_b),
    .s (sel),
    .y (mem_addr)
  );

  assign mem_valid = in_req;
  assign mem_we    = in_req & sel & we_b;
  assign gnt_a     = in_req & mem_ready & (sel == OWN_A);
  assign gnt_b     = in_req & mem_ready & (sel == OWN_B);
  // A response landing on the timeout cycle still counts as a completion.
  assign done_a    = in_wait & mem_rvalid & (sel == OWN_A);
  assign done_b    = in_wait & mem_rvalid & (sel == OWN_B);
  assign err_o     = timeout_hit & ~mem_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios for mem_port_arbiter with a grant scoreboard
// (expected owner/address/write pushed at stimulus, observed pushed on each grant).
module tb_mem_port_arbiter;

  localparam int AW      = 32;
  localparam int TIMEOUT = 16;

  logic          clk;
  logic          rst_n;
  logic          req_a;
  logic [AW-1:0] addr_a;
  logic          req_b;
  logic [AW-1:0] addr_b;
  logic          we_b;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_rvalid;
  logic          sel;
  logic          gnt_a;
  logic          gnt_b;
  logic          done_a;
  logic          done_b;
  logic          err_o;

  int n_tests;
  int n_fail;

  logic [AW+2:0] exp_q[$];
  logic [AW+2:0] obs_q[$];

  mem_port_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_a      (req_a),
    .addr_a     (addr_a),
    .req_b      (req_b),
    .addr_b     (addr_b),
    .we_b       (we_b),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_rvalid (mem_rvalid),
    .sel        (sel),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b),
    .done_a     (done_a),
    .done_b     (done_b),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grant monitor: {owner, sel, mem_we, mem_addr} captured on every accepted request.
  always @(negedge clk) begin
    if (rst_n && (gnt_a || gnt_b))
      obs_q.push_back({gnt_b, sel, mem_we, mem_addr});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; addr_a = 32'h55; addr_b = 32'h66;
    we_b = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({mem_valid, mem_we, sel, gnt_a, gnt_b, done_a, done_b, err_o} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {mem_valid, mem_we, sel, gnt_a, gnt_b, done_a, done_b, err_o});
    end
    n_tests++;
    if (mem_addr !== 32'h55) begin
      n_fail++;
      $display("FAIL reset_addr: got %h want %h", mem_addr, 32'h55);
    end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_only_a();
    next_cycle();
    req_a = 1'b1; addr_a = 32'h100; mem_ready = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 1'b0, 32'h100});
    @(negedge clk);
    n_tests++;
    if (mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL only_a_idle_valid: got %b want 0", mem_valid);
    end
    @(negedge clk);
    n_tests++;
    if ({mem_valid, sel, gnt_a, gnt_b, mem_addr} !== {4'b1010, 32'h100}) begin
      n_fail++;
      $display("FAIL only_a_req: got v=%b s=%b ga=%b gb=%b a=%h want v=1 s=0 ga=1 gb=0 a=100",
               mem_valid, sel, gnt_a, gnt_b, mem_addr);
    end
    next_cycle();
    mem_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({mem_valid, done_a, done_b, err_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL only_a_wait1: got %b want 0000", {mem_valid, done_a, done_b, err_o});
    end
    next_cycle();
    mem_rvalid = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({done_a, done_b, err_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL only_a_done: got %b want 100", {done_a, done_b, err_o});
    end
    next_cycle();
    mem_rvalid = 1'b0; req_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({mem_valid, done_a, gnt_a} !== 3'b000) begin
      n_fail++;
      $display("FAIL only_a_back_idle: got %b want 000", {mem_valid, done_a, gnt_a});
    end
  endtask

  task automatic test_conflict();
    logic own;
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    req_a = 1'b1; req_b = 1'b1; addr_a = 32'hA0; addr_b = 32'hB0; we_b = 1'b1;
    mem_ready = 1'b1; mem_rvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      own = (k == 1);
      exp_q.push_back({own, own, own, own ? 32'hB0 : 32'hA0});
      @(negedge clk);
      n_tests++;
      if (mem_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL conflict_idle[%0d]: valid got %b want 0", k, mem_valid);
      end
      @(negedge clk);
      n_tests++;
      if ({sel, gnt_a, gnt_b, mem_we, mem_addr} !== {own, ~own, own, own, own ? 32'hB0 : 32'hA0}) begin
        n_fail++;
        $display("FAIL conflict_req[%0d]: got s=%b ga=%b gb=%b we=%b a=%h want owner %b", k,
                 sel, gnt_a, gnt_b, mem_we, mem_addr, own);
      end
      @(negedge clk);
      n_tests++;
      if ({done_a, done_b, err_o} !== {~own, own, 1'b0}) begin
        n_fail++;
        $display("FAIL conflict_done[%0d]: got %b want %b", k, {done_a, done_b, err_o},
                 {~own, own, 1'b0});
      end
    end
    next_cycle();
    req_a = 1'b0; req_b = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; we_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    next_cycle();
    req_b = 1'b1; addr_b = 32'h2C0; addr_a = 32'h111; we_b = 1'b0; mem_ready = 1'b0;
    exp_q.push_back({1'b1, 1'b1, 1'b0, 32'h2C0});
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      if (i == 4) mem_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({mem_valid, sel, mem_we, gnt_a, gnt_b, mem_addr} !== {4'b1100, (i == 4), 32'h2C0}) begin
        n_fail++;
        $display("FAIL backpressure_req[%0d]: got v=%b s=%b we=%b ga=%b gb=%b a=%h want gb=%0d", i,
                 mem_valid, sel, mem_we, gnt_a, gnt_b, mem_addr, (i == 4));
      end
    end
    next_cycle();
    mem_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({mem_valid, gnt_b, done_b} !== 3'b000) begin
      n_fail++;
      $display("FAIL backpressure_wait: got %b want 000", {mem_valid, gnt_b, done_b});
    end
    next_cycle();
    mem_rvalid = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({done_a, done_b, err_o} !== 3'b010) begin
      n_fail++;
      $display("FAIL backpressure_done: got %b want 010", {done_a, done_b, err_o});
    end
    next_cycle();
    mem_rvalid = 1'b0; req_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout(input bit tie);
    logic exp_err;
    logic exp_done;
    next_cycle();
    req_a = 1'b1; addr_a = 32'h3F0; mem_ready = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 1'b0, 32'h3F0});
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (gnt_a !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_gnt[tie=%0d]: got %b want 1", tie, gnt_a);
    end
    for (int w = 1; w <= TIMEOUT; w++) begin
      next_cycle();
      mem_ready = 1'b0;
      if (tie && (w == TIMEOUT)) mem_rvalid = 1'b1;
      @(negedge clk);
      exp_err  = (w == TIMEOUT) && !tie;
      exp_done = (w == TIMEOUT) && tie;
      n_tests++;
      if ({err_o, done_a, done_b, mem_valid} !== {exp_err, exp_done, 2'b00}) begin
        n_fail++;
        $display("FAIL timeout_wait[tie=%0d,cyc=%0d]: got err=%b da=%b db=%b v=%b want err=%b da=%b",
                 tie, w, err_o, done_a, done_b, mem_valid, exp_err, exp_done);
      end
    end
    next_cycle();
    mem_rvalid = 1'b0; req_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({mem_valid, err_o, done_a} !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout_idle[tie=%0d]: got %b want 000", tie, {mem_valid, err_o, done_a});
    end
  endtask

  task automatic test_stray_and_reset();
    next_cycle();
    mem_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if ({gnt_a, gnt_b, done_a, done_b, err_o, mem_valid} !== 6'b000000) begin
        n_fail++;
        $display("FAIL stray_rvalid[%0d]: got %b want 000000", i,
                 {gnt_a, gnt_b, done_a, done_b, err_o, mem_valid});
      end
    end
    next_cycle();
    mem_rvalid = 1'b0; req_a = 1'b1; req_b = 1'b1;
    addr_a = 32'h400; addr_b = 32'h500; we_b = 1'b1; mem_ready = 1'b1;
    exp_q.push_back({1'b1, 1'b1, 1'b1, 32'h500});
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({sel, gnt_b, mem_addr} !== {2'b11, 32'h500}) begin
      n_fail++;
      $display("FAIL rr_after_a: got s=%b gb=%b a=%h want s=1 gb=1 a=500", sel, gnt_b, mem_addr);
    end
    next_cycle();
    mem_ready = 1'b0;
    @(negedge clk);
    next_cycle();
    rst_n = 1'b0; mem_rvalid = 1'b1;
    #1;
    n_tests++;
    if ({mem_valid, mem_we, sel, gnt_a, gnt_b, done_a, done_b, err_o} !== 8'h00 ||
        mem_addr !== 32'h400) begin
      n_fail++;
      $display("FAIL reset_in_wait: got %b a=%h want 00000000 a=400",
               {mem_valid, mem_we, sel, gnt_a, gnt_b, done_a, done_b, err_o}, mem_addr);
    end
    @(negedge clk);
    n_tests++;
    if ({done_a, done_b, err_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_held_pulses: got %b want 000", {done_a, done_b, err_o});
    end
    next_cycle();
    rst_n = 1'b1; mem_ready = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 1'b0, 32'h400});
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({sel, gnt_a, gnt_b, mem_addr} !== {3'b010, 32'h400}) begin
      n_fail++;
      $display("FAIL post_reset_conflict: got s=%b ga=%b gb=%b a=%h want s=0 ga=1 gb=0 a=400",
               sel, gnt_a, gnt_b, mem_addr);
    end
    @(negedge clk);
    n_tests++;
    if ({done_a, done_b} !== 2'b10) begin
      n_fail++;
      $display("FAIL post_reset_done: got %b want 10", {done_a, done_b});
    end
    next_cycle();
    req_a = 1'b0; req_b = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; we_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_scoreboard();
    logic [AW+2:0] e;
    logic [AW+2:0] o;
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL sb_count: got %0d grants want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL sb_grant: got own=%b sel=%b we=%b a=%h want own=%b sel=%b we=%b a=%h",
                 o[AW+2], o[AW+1], o[AW], o[AW-1:0], e[AW+2], e[AW+1], e[AW], e[AW-1:0]);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_only_a();
    test_conflict();
    test_backpressure();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_stray_and_reset();
    test_scoreboard();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
